// File: rtl/ship_board.sv
// Own-fleet board: places ship cells from pick_ship clicks, answers opponent shots, serves a renderer read port.
// Latency: placement lands 3 cycles after the click edge; shot response 1 cycle after acceptance; rd_data 1 cycle.
// Backpressure: clicks outside PLACE are dropped (not queued); shots are accepted only while shot_ready is high.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   clear                         new-game pulse, same effect as rst
//   pick_ship, mouse_position     placement click level and cursor {row[7:4], col[3:0]}
//   place_err, ship_count         placement rejected pulse, cells placed so far
//   placing_done                  fleet armed (ARMED/SHOT)
//   shot_valid/ready, shot_position  opponent shot handshake and target
//   shot_resp_valid, shot_hit, shot_repeat  shot result pulse and qualifiers
//   fleet_sunk                    sticky, all ship cells hit
//   rd_addr, rd_data              renderer query, 0 empty / 1 ship / 2 miss / 3 hit
module ship_board #(
    parameter int BOARD_SIZE = 10,
    parameter int MAX_CELLS  = 11,
    parameter bit ADJ_CHECK  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       pick_ship,
    input  logic [7:0] mouse_position,
    output logic       place_err,
    output logic [3:0] ship_count,
    output logic       placing_done,
    input  logic       shot_valid,
    input  logic [7:0] shot_position,
    output logic       shot_ready,
    output logic       shot_resp_valid,
    output logic       shot_hit,
    output logic       shot_repeat,
    output logic       fleet_sunk,
    input  logic [7:0] rd_addr,
    output logic [1:0] rd_data
);

    localparam int         NCELLS = BOARD_SIZE * BOARD_SIZE;
    localparam int         IDX_W  = 7;
    localparam logic [3:0] BS     = 4'(BOARD_SIZE);
    localparam logic [3:0] MAXC   = 4'(MAX_CELLS);

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_SHIP  = 2'd1;
    localparam logic [1:0] CELL_MISS  = 2'd2;
    localparam logic [1:0] CELL_HIT   = 2'd3;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } pos_t;

    typedef enum logic [2:0] {
        S_PLACE,
        S_CHECK,
        S_WRITE,
        S_ARMED,
        S_SHOT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] board [NCELLS];
    logic       pick_prev;
    pos_t       pos_q;
    pos_t       shot_q;
    logic [3:0] hits;

    logic       abort;
    logic       pick_edge;
    logic       place_bad;
    logic       adj_ship;
    logic [1:0] shot_cell;
    logic       shot_rep_int;
    logic       shot_hit_int;

    function automatic logic in_range(input pos_t p);
        return (p.row < BS) && (p.col < BS);
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input pos_t p);
        return IDX_W'(int'(p.row) * BOARD_SIZE + int'(p.col));
    endfunction

    // Out-of-range positions read as empty so callers never index past the array.
    function automatic logic [1:0] cell_at(input pos_t p);
        logic [1:0] v;
        v = CELL_EMPTY;
        if (in_range(p)) v = board[cell_idx(p)];
        return v;
    endfunction

    // Diagonal neighbour; 4-bit wrap of row/col 0 minus 1 gives 0xF, which reads as out of range.
    function automatic logic diag_ship(input pos_t p, input logic up, input logic left);
        pos_t n;
        n.row = up   ? p.row - 4'd1 : p.row + 4'd1;
        n.col = left ? p.col - 4'd1 : p.col + 4'd1;
        return cell_at(n) == CELL_SHIP;
    endfunction

    assign abort     = rst | clear;
    assign pick_edge = pick_ship & ~pick_prev;

    always_comb begin
        adj_ship = 1'b0;
        if (ADJ_CHECK) begin
            adj_ship = diag_ship(pos_q, 1'b1, 1'b1) | diag_ship(pos_q, 1'b1, 1'b0) |
                       diag_ship(pos_q, 1'b0, 1'b1) | diag_ship(pos_q, 1'b0, 1'b0);
        end
        place_bad = !in_range(pos_q) || (cell_at(pos_q) != CELL_EMPTY) || adj_ship;
    end

    // Once the fleet is sunk every further shot is reported as a repeat and nothing is written.
    always_comb begin
        shot_cell    = cell_at(shot_q);
        shot_rep_int = fleet_sunk || !in_range(shot_q) || shot_cell[1];
        shot_hit_int = !shot_rep_int && (shot_cell == CELL_SHIP);
    end

    always_comb begin
        state_d         = state_q;
        place_err       = 1'b0;
        shot_ready      = 1'b0;
        shot_resp_valid = 1'b0;
        shot_hit        = 1'b0;
        shot_repeat     = 1'b0;
        case (state_q)
            S_PLACE: begin
                if (pick_edge) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (place_bad) begin
                    place_err = ~abort;
                    state_d   = S_PLACE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if ((ship_count == MAXC) || (ship_count + 4'd1 == MAXC)) state_d = S_ARMED;
                else                                                    state_d = S_PLACE;
            end
            S_ARMED: begin
                shot_ready = ~abort;
                if (shot_valid) state_d = S_SHOT;
            end
            S_SHOT: begin
                shot_resp_valid = ~abort;
                shot_hit        = ~abort & shot_hit_int;
                shot_repeat     = ~abort & shot_rep_int;
                state_d         = S_ARMED;
            end
            default: state_d = S_PLACE;
        endcase
    end

    assign placing_done = (state_q == S_ARMED) || (state_q == S_SHOT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= S_PLACE;
            pick_prev  <= 1'b0;
            pos_q      <= '0;
            shot_q     <= '0;
            ship_count <= '0;
            hits       <= '0;
            fleet_sunk <= 1'b0;
            rd_data    <= CELL_EMPTY;
            for (int i = 0; i < NCELLS; i++) board[i] <= CELL_EMPTY;
        end else begin
            state_q   <= state_d;
            pick_prev <= pick_ship;
            rd_data   <= cell_at(rd_addr);

            if (state_q == S_PLACE && pick_edge) pos_q <= mouse_position;
            if (state_q == S_ARMED && shot_valid) shot_q <= shot_position;

            // pos_q is known in range here: CHECK rejected anything else.
            if (state_q == S_WRITE) begin
                board[cell_idx(pos_q)] <= CELL_SHIP;
                if (ship_count != MAXC) ship_count <= ship_count + 4'd1;
            end

            if (state_q == S_SHOT && !shot_rep_int) begin
                board[cell_idx(shot_q)] <= shot_hit_int ? CELL_HIT : CELL_MISS;
                if (shot_hit_int) begin
                    hits <= hits + 4'd1;
                    if (hits + 4'd1 == MAXC) fleet_sunk <= 1'b1;
                end
            end
        end
    end

endmodule
